// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states and
// the helper that aligns a byte offset to the access size.
package dm_arb_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_CPU = 2'd1,
        ST_RD_EXT = 2'd2
    } state_t;

    // Misaligned words use offset 0 and misaligned halves drop bit 0; the
    // encoding 2'b11 behaves as a word.
    function automatic logic [1:0] norm_off(input logic [1:0] size,
                                            input logic [1:0] off);
        logic [1:0] r;
        case (size)
            SZ_BYTE: r = off;
            SZ_HALF: r = {off[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane logic: places CPU store data onto the memory lanes
// with byte enables, and extracts/extends CPU load data from the read word.
module dm_lane_align
    import dm_arb_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [1:0]  st_lane;
    logic [1:0]  ld_lane;
    logic [31:0] ld_shift;

    always_comb begin
        st_lane  = norm_off(st_size, st_off);
        st_be    = BE_WORD;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_lane  = norm_off(ld_size, ld_off);
        // Bring the selected lane down to bit 0 before extending.
        ld_shift = ld_word >> {ld_lane, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sign & ld_shift[7]}},  ld_shift[7:0]};
            SZ_HALF: ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data memory arbiter between the CPU M stage and an external
// requester. Optional misalignment trap: define DM_ALIGN_CHECK_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int   ADDR_W  = 12,
    parameter logic RR_INIT = 1'b0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
`ifdef DM_ALIGN_CHECK_EN
    output logic              cpu_err,
`endif
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [3:0]        ext_be,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic [31:0]       ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      state, state_nxt;
    logic        rr, rr_nxt;
    logic        gnt_cpu, gnt_ext;
    logic        misal, cpu_ok, err;
    logic        rd_cpu, rd_ext;
    logic [1:0]  ld_size, ld_off;
    logic        ld_sign;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], ext_addr[31:ADDR_W+2],
                                ext_addr[1:0]};

`ifdef DM_ALIGN_CHECK_EN
    always_comb begin
        case (cpu_size)
            SZ_BYTE: misal = 1'b0;
            SZ_HALF: misal = cpu_addr[0];
            default: misal = |cpu_addr[1:0];
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    assign cpu_ok = cpu_req & ~misal;

    dm_lane_align u_lane (
        .st_size  (cpu_size),
        .st_off   (cpu_addr[1:0]),
        .st_data  (cpu_wdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_size  (ld_size),
        .ld_off   (ld_off),
        .ld_sign  (ld_sign),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data)
    );

    // Reset gates every grant and completion so it dominates same-cycle
    // requests and discards a read in flight.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        gnt_cpu   = 1'b0;
        gnt_ext   = 1'b0;
        err       = 1'b0;
        if (!Reset) begin
            case (state)
                ST_IDLE: begin
                    err = cpu_req & misal;
                    if (cpu_ok && (!ext_req || !rr))
                        gnt_cpu = 1'b1;
                    else if (ext_req)
                        gnt_ext = 1'b1;
                    if (gnt_cpu) begin
                        rr_nxt    = 1'b1;
                        state_nxt = cpu_we ? ST_IDLE : ST_RD_CPU;
                    end
                    if (gnt_ext) begin
                        rr_nxt    = 1'b0;
                        state_nxt = ext_we ? ST_IDLE : ST_RD_EXT;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= ST_IDLE;
            rr      <= RR_INIT;
            ld_size <= 2'b00;
            ld_off  <= 2'b00;
            ld_sign <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            if (gnt_cpu && !cpu_we) begin
                ld_size <= cpu_size;
                ld_off  <= cpu_addr[1:0];
                ld_sign <= cpu_sign;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (gnt_cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we ? st_be : 4'b0000;
            mem_addr  = cpu_addr[ADDR_W+1:2];
            mem_wdata = st_wdata;
        end else if (gnt_ext) begin
            mem_en    = 1'b1;
            mem_we    = ext_we ? ext_be : 4'b0000;
            mem_addr  = ext_addr[ADDR_W+1:2];
            mem_wdata = ext_wdata;
        end
    end

    assign rd_cpu     = (state == ST_RD_CPU) & ~Reset;
    assign rd_ext     = (state == ST_RD_EXT) & ~Reset;

    assign cpu_stall  = cpu_req & ~((gnt_cpu & cpu_we) | rd_cpu | err);
    assign cpu_rvalid = rd_cpu;
    assign cpu_rdata  = rd_cpu ? ld_data : 32'h0;
    assign ext_gnt    = gnt_ext;
    assign ext_rvalid = rd_ext;
    assign ext_rdata  = rd_ext ? mem_rdata : 32'h0;

`ifdef DM_ALIGN_CHECK_EN
    assign cpu_err = err;

    always_ff @(posedge CLK) begin
        if (err)
            $display("%0t dm_arbiter: misaligned cpu access at %h", $time, cpu_addr);
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios followed by randomized CPU/external
// traffic checked against a byte-level shadow memory.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, cpu_sign;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic [3:0]  ext_be;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DM_ALIGN_CHECK_EN
    logic        cpu_err;
`endif

    int nchecks = 0;
    int nerr    = 0;

    logic [31:0] mem_arr [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        init_mem;

    dm_arbiter #(.ADDR_W(12), .RR_INIT(1'b0)) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
`ifdef DM_ALIGN_CHECK_EN
        .cpu_err(cpu_err),
`endif
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_be(ext_be),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .ext_rvalid(ext_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h80C0FFEE;
        if (i == 1) return 32'h11223344;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Synchronous single-port memory, 1-cycle read latency.
    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= init_word(i);
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0000) mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Reference semantics written from byte-address arithmetic.
    function automatic logic [31:0] ref_ld(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        if (sz == 2'b01) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b10) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [31:0] ref_st(input logic [31:0] old, input logic [31:0] a,
                                           input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] m;
        int          sh;
        if (sz == 2'b01) begin
            sh = 8 * a[1:0];
            m  = 32'hFF << sh;
            return (old & ~m) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b10) begin
            sh = 16 * a[1];
            m  = 32'hFFFF << sh;
            return (old & ~m) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    function automatic logic [31:0] ref_be(input logic [31:0] old, input logic [3:0] be,
                                           input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    // Present one load, hold until stall drops (bounded), check the data.
    task automatic cpu_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic sg, input logic [31:0] exp,
                            output int stalls, output int cycles);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = sz; cpu_sign = sg; cpu_addr = a;
        stalls = 0; cycles = 0;
        for (int k = 0; k < 8; k++) begin
            smp;
            cycles++;
            if (!cpu_stall || k == 7) break;
            stalls++;
            tick;
        end
        chk({tag, "_stall_end"}, {31'b0, cpu_stall}, 32'h0);
        chk({tag, "_rvalid"}, {31'b0, cpu_rvalid}, 32'h1);
        chk(tag, cpu_rdata, exp);
        tick;
        cpu_req = 1'b0;
    endtask

    int          st, cy, cpu_run, ext_run;
    logic        cpu_act, ext_act, ext_pend;
    logic [11:0] pend_idx;
    logic [1:0]  off;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        init_mem = 1'b1;
        Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_sign = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_be = 0; ext_wdata = 0;
        tick;
        init_mem = 1'b0;

        // Reset dominates simultaneous requests.
        cpu_req = 1'b1; cpu_we = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
        smp;
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
        chk("rst_ext_gnt", {31'b0, ext_gnt}, 32'h0);
        chk("rst_rvalid", {30'b0, cpu_rvalid, ext_rvalid}, 32'h0);
        tick;
        cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0;
        Reset = 1'b0;
        smp;
        chk("idle_mem_en", {31'b0, mem_en}, 32'h0);
        chk("idle_stall", {31'b0, cpu_stall}, 32'h0);
        tick;

        // sb 0xAB at byte 6 over 0x11223344.
        cpu_req = 1; cpu_we = 1; cpu_size = SZ_BYTE; cpu_addr = 32'h6; cpu_wdata = 32'hAB;
        smp;
        chk("sb_mem_en", {31'b0, mem_en}, 32'h1);
        chk("sb_mem_we", {28'b0, mem_we}, 32'h4);
        chk("sb_mem_addr", {20'b0, mem_addr}, 32'h1);
        chk("sb_mem_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_stall", {31'b0, cpu_stall}, 32'h0);
        tick;
        cpu_req = 0;
        cpu_load("lw_after_sb", 32'h4, SZ_WORD, 1'b0, 32'h11AB3344, st, cy);
        chk("lw_stalls", st, 1);

        // Back-to-back byte loads of 0x80.
        cpu_load("lb", 32'h3, SZ_BYTE, 1'b1, 32'hFFFFFF80, st, cy);
        chk("lb_stalls", st, 1);
        chk("lb_cycles", cy, 2);
        cpu_load("lbu", 32'h3, SZ_BYTE, 1'b0, 32'h00000080, st, cy);
        chk("lbu_stalls", st, 1);
        chk("lbu_cycles", cy, 2);
        cpu_load("lh", 32'h2, SZ_HALF, 1'b1, 32'hFFFF80C0, st, cy);
        cpu_load("lw_wrap", 32'hFFFFC004, SZ_WORD, 1'b0, 32'h11AB3344, st, cy);

        // Contention with rr freshly reset.
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_size = SZ_WORD; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
        ext_req = 1; ext_we = 1; ext_addr = 32'h24; ext_be = 4'hF; ext_wdata = 32'hCAFEF00D;
        smp;
        chk("conA_stall", {31'b0, cpu_stall}, 32'h0);
        chk("conA_ext_gnt", {31'b0, ext_gnt}, 32'h0);
        chk("conA_addr", {20'b0, mem_addr}, 32'h8);
        tick;
        cpu_req = 0;
        smp;
        chk("conA_ext_gnt2", {31'b0, ext_gnt}, 32'h1);
        chk("conA_addr2", {20'b0, mem_addr}, 32'h9);
        tick;
        // After the uncontested ext grant the CPU is favoured again.
        cpu_req = 1; cpu_addr = 32'h28; cpu_wdata = 32'hA5A5A5A5;
        ext_addr = 32'h2C; ext_wdata = 32'h0BADF00D;
        smp;
        chk("conB_cpu_first", {20'b0, mem_addr}, 32'hA);
        chk("conB_stall0", {31'b0, cpu_stall}, 32'h0);
        tick;
        cpu_size = SZ_HALF; cpu_addr = 32'h32; cpu_wdata = 32'h0000BEEF;
        smp;
        chk("conB_ext_wins", {31'b0, ext_gnt}, 32'h1);
        chk("conB_stall1", {31'b0, cpu_stall}, 32'h1);
        tick;
        ext_req = 0;
        smp;
        chk("conB_stall2", {31'b0, cpu_stall}, 32'h0);
        chk("conB_sh_we", {28'b0, mem_we}, 32'hC);
        chk("conB_sh_wdata", mem_wdata, 32'hBEEFBEEF);
        tick;
        cpu_req = 0;

        // Ext read, CPU load arriving during RD_EXT.
        ext_req = 1; ext_we = 0; ext_addr = 32'h26;
        smp;
        chk("xr_gnt", {31'b0, ext_gnt}, 32'h1);
        chk("xr_mem_we", {28'b0, mem_we}, 32'h0);
        tick;
        ext_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_size = SZ_WORD; cpu_addr = 32'h20;
        smp;
        chk("xr_rvalid", {31'b0, ext_rvalid}, 32'h1);
        chk("xr_rdata", ext_rdata, 32'hCAFEF00D);
        chk("xr_cpu_wait", {31'b0, cpu_stall}, 32'h1);
        chk("xr_no_issue", {31'b0, mem_en}, 32'h0);
        tick;
        smp;
        chk("xr_cpu_issue", {31'b0, mem_en}, 32'h1);
        chk("xr_cpu_wait2", {31'b0, cpu_stall}, 32'h1);
        tick;
        smp;
        chk("xr_cpu_done", {31'b0, cpu_stall}, 32'h0);
        chk("xr_cpu_rdata", cpu_rdata, 32'h12345678);
        tick;
        cpu_req = 0;

        // Reset while a CPU read is in flight.
        cpu_req = 1; cpu_addr = 32'h20;
        smp;
        chk("rrd_stall", {31'b0, cpu_stall}, 32'h1);
        tick;
        Reset = 1; cpu_req = 0;
        smp;
        chk("rrd_no_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        tick;
        Reset = 0;
        smp;
        chk("rrd_no_rvalid2", {31'b0, cpu_rvalid}, 32'h0);
        chk("rrd_mem_en", {31'b0, mem_en}, 32'h0);
        tick;

        // Misaligned lw at address 2.
`ifdef DM_ALIGN_CHECK_EN
        cpu_req = 1; cpu_we = 0; cpu_size = SZ_WORD; cpu_addr = 32'h2;
        smp;
        chk("mis_err", {31'b0, cpu_err}, 32'h1);
        chk("mis_mem_en", {31'b0, mem_en}, 32'h0);
        chk("mis_stall", {31'b0, cpu_stall}, 32'h0);
        tick;
        cpu_req = 0;
`else
        cpu_load("mis_lw", 32'h2, SZ_WORD, 1'b0, 32'h80C0FFEE, st, cy);
`endif

        // Randomized traffic over words 64..79 (untouched above).
        cpu_act = 0; ext_act = 0; ext_pend = 0; pend_idx = 0; cpu_run = 0; ext_run = 0;
        for (int c = 0; c < 800; c++) begin
            if (!cpu_act) begin
                if ($urandom_range(9) < 6) begin
                    cpu_act   = 1;
                    cpu_we    = 1'($urandom_range(1));
                    cpu_size  = 2'($urandom_range(3));
                    off       = (cpu_size == SZ_BYTE) ? 2'($urandom_range(3)) :
                                (cpu_size == SZ_HALF) ? 2'($urandom_range(1) * 2) : 2'b00;
                    cpu_addr  = ($urandom & 32'hFFFFC000) |
                                (32'(64 + $urandom_range(15)) << 2) | 32'(off);
                    cpu_sign  = 1'($urandom_range(1));
                    cpu_wdata = $urandom;
                    cpu_req   = 1;
                    cpu_run   = 0;
                end else cpu_req = 0;
            end
            if (!ext_act) begin
                if ($urandom_range(9) < 4) begin
                    ext_act   = 1;
                    ext_we    = 1'($urandom_range(1));
                    ext_addr  = ($urandom & 32'hFFFFC003) | (32'(64 + $urandom_range(15)) << 2);
                    ext_be    = 4'($urandom_range(15));
                    ext_wdata = $urandom;
                    ext_req   = 1;
                    ext_run   = 0;
                end else ext_req = 0;
            end
            smp;
            if (cpu_rvalid) begin
                chk("r_cpu_rv_owner", {31'b0, cpu_act & ~cpu_we}, 32'h1);
                chk("r_cpu_rdata", cpu_rdata,
                    ref_ld(ref_mem[cpu_addr[13:2]], cpu_addr, cpu_size, cpu_sign));
            end
            if (ext_rvalid) begin
                chk("r_ext_rv_owner", {31'b0, ext_pend}, 32'h1);
                chk("r_ext_rdata", ext_rdata, ref_mem[pend_idx]);
                ext_pend = 0;
            end
            if (cpu_req && !cpu_stall) begin
                if (cpu_we)
                    ref_mem[cpu_addr[13:2]] = ref_st(ref_mem[cpu_addr[13:2]], cpu_addr,
                                                     cpu_size, cpu_wdata);
                else
                    chk("r_cpu_ld_rv", {31'b0, cpu_rvalid}, 32'h1);
                chk("r_cpu_wait", {31'b0, cpu_run <= 3}, 32'h1);
                cpu_act = 0;
            end else if (cpu_req) cpu_run++;
            if (ext_gnt) begin
                chk("r_gnt_req", {31'b0, ext_req}, 32'h1);
                if (ext_we)
                    ref_mem[ext_addr[13:2]] = ref_be(ref_mem[ext_addr[13:2]], ext_be, ext_wdata);
                else begin
                    ext_pend = 1;
                    pend_idx = ext_addr[13:2];
                end
                chk("r_ext_wait", {31'b0, ext_run <= 3}, 32'h1);
                ext_act = 0;
            end else if (ext_req) ext_run++;
            tick;
        end
        cpu_req = 0; ext_req = 0;
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
